cache_mem_ctrl: RTL and testbench

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

---
 rtl/cache_mem_ctrl_if.sv | 38 +++
 rtl/cache_mem_ctrl.sv | 108 ++++++++++
 tb/tb_cache_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_ctrl_if.sv
// Purpose: bundles the cache-side request/done signals and the memory beat bus of cache_mem_ctrl.
// Latency: none, wiring only.
// Backpressure: memory side stalls via mem_ack; cache side holds req levels until the done pulse.
interface cache_mem_ctrl_if #(
  parameter int BEATS  = 4,
  parameter int LINE_W = 32 * BEATS
);
  // cache side
  logic              wb_req;
  logic [31:0]       wb_addr;
  logic [LINE_W-1:0] wb_line;
  logic              wb_done;
  logic              fill_req;
  logic [31:0]       fill_addr;
  logic [LINE_W-1:0] fill_line;
  logic              fill_done;
  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  // status
  logic              busy;

  // controller view
  modport slave (
    input  wb_req, wb_addr, wb_line, fill_req, fill_addr, mem_rdata, mem_ack,
    output wb_done, fill_line, fill_done, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  // cache + memory model view
  modport master (
    output wb_req, wb_addr, wb_line, fill_req, fill_addr, mem_rdata, mem_ack,
    input  wb_done, fill_line, fill_done, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Purpose: moves whole cache lines to/from a 32-bit memory as BEATS-word bursts (writeback or fill).
// Latency: BEATS acked beats after leaving IDLE, then a one-cycle done pulse; one IDLE cycle between bursts.
// Backpressure: each beat holds address/data until mem_ack; no timeout, requests wait in IDLE while busy.
module cache_mem_ctrl #(
  parameter int BEATS  = 4,
  parameter int LINE_W = 32 * BEATS
) (
  input logic            clk,
  input logic            rst_n,
  cache_mem_ctrl_if.slave bus
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [31:0]   LINE_MASK = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q;
  logic [31:0]       base_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] fill_line_q;
  logic              was_wb_q;
  logic              beat_ack;
  logic [BW+4:0]     word_off;

  // an ack only counts while a beat is actually being presented
  assign beat_ack = bus.mem_req && bus.mem_ack;
  // bit offset of the current 32-bit word inside the line
  assign word_off = {beat_q, 5'd0};
  assign bus.fill_line = fill_line_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: writeback has priority so a dirty victim leaves before its slot is refilled
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.wb_req)        state_d = WB;
        else if (bus.fill_req) state_d = FILL;
      end
      WB, FILL: begin
        if (beat_ack && beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // beat bus and done pulses decode straight from registered state, so reset clears them at once
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wb_done   = 1'b0;
    bus.fill_done = 1'b0;
    bus.busy      = (state_q != IDLE);
    unique case (state_q)
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = base_q + {{(30 - BW){1'b0}}, beat_q, 2'b00};
        bus.mem_wdata = line_q[word_off +: 32];
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = base_q + {{(30 - BW){1'b0}}, beat_q, 2'b00};
      end
      DONE: begin
        bus.wb_done   = was_wb_q;
        bus.fill_done = !was_wb_q;
      end
      default: ;
    endcase
  end

  // burst datapath: snapshot address/line when leaving IDLE, then advance one word per acked beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      base_q      <= '0;
      line_q      <= '0;
      fill_line_q <= '0;
      was_wb_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      beat_q <= '0;
      if (bus.wb_req) begin
        base_q   <= bus.wb_addr & LINE_MASK;
        line_q   <= bus.wb_line;
        was_wb_q <= 1'b1;
      end else if (bus.fill_req) begin
        base_q   <= bus.fill_addr & LINE_MASK;
        was_wb_q <= 1'b0;
      end
    end else if ((state_q == WB || state_q == FILL) && beat_ack) begin
      beat_q <= beat_q + BW'(1);
      if (state_q == FILL) fill_line_q[word_off +: 32] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Purpose: directed checks of cache_mem_ctrl bursts, stalls, priority, input capture, reset abort and stray acks.
// Latency: outputs sampled 1 time unit after each rising edge; done expected one cycle after the last acked beat.
// Backpressure: the bench plays memory, driving mem_ack patterns (every cycle, every third cycle, stray).
module tb_cache_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  cache_mem_ctrl_if bus ();

  cache_mem_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // advance one cycle and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {mem_req, mem_we, busy, wb_done, fill_done, mem_wdata}
  function automatic logic [36:0] ctl();
    return {bus.mem_req, bus.mem_we, bus.busy, bus.wb_done, bus.fill_done, bus.mem_wdata};
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL reset_ctl got %h want %h", ctl(), 37'h0);
    end
    total++;
    if (bus.mem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_addr got %h want %h", bus.mem_addr, 32'h0);
    end
    total++;
    if (bus.fill_line !== 128'h0) begin
      bad++; $display("FAIL reset_fill_line got %h want %h", bus.fill_line, 128'h0);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL reset_release_idle got %h want %h", ctl(), 37'h0);
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd [4];
    rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.fill_addr = 32'h0000_1234;
    bus.fill_req  = 1'b1;
    bus.mem_ack   = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ctl(), bus.mem_addr} !== {5'b10100, 32'h0, 32'(32'h1230 + 4 * k)}) begin
        bad++; $display("FAIL fill_beat%0d got %h want %h", k, {ctl(), bus.mem_addr},
                        {5'b10100, 32'h0, 32'(32'h1230 + 4 * k)});
      end
      bus.mem_rdata = rd[k];
      tick();
    end
    total++;
    if (ctl() !== {5'b00101, 32'h0}) begin
      bad++; $display("FAIL fill_done got %h want %h", ctl(), {5'b00101, 32'h0});
    end
    total++;
    if (bus.fill_line !== 128'h00000044_00000033_00000022_00000011) begin
      bad++; $display("FAIL fill_line got %h want %h", bus.fill_line, 128'h00000044_00000033_00000022_00000011);
    end
    bus.fill_req = 1'b0;
    bus.mem_ack  = 1'b0;
    tick();
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL fill_after_done got %h want %h", ctl(), 37'h0);
    end
    total++;
    if (bus.fill_line !== 128'h00000044_00000033_00000022_00000011) begin
      bad++; $display("FAIL fill_line_hold got %h want %h", bus.fill_line, 128'h00000044_00000033_00000022_00000011);
    end
  endtask

  task automatic test_wb_stall();
    logic [31:0] w [4];
    w = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    bus.wb_addr = 32'h8000_0010;
    bus.wb_line = {w[3], w[2], w[1], w[0]};
    bus.wb_req  = 1'b1;
    bus.mem_ack = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        total++;
        if ({ctl(), bus.mem_addr} !== {5'b11100, w[k], 32'(32'h8000_0010 + 4 * k)}) begin
          bad++; $display("FAIL wb_stall_beat%0d_cyc%0d got %h want %h", k, s, {ctl(), bus.mem_addr},
                          {5'b11100, w[k], 32'(32'h8000_0010 + 4 * k)});
        end
        bus.mem_ack = (s == 2);
        tick();
      end
    end
    total++;
    if (ctl() !== {5'b00110, 32'h0}) begin
      bad++; $display("FAIL wb_stall_done got %h want %h", ctl(), {5'b00110, 32'h0});
    end
    bus.wb_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL wb_stall_after_done got %h want %h", ctl(), 37'h0);
    end
  endtask

  task automatic test_input_change();
    logic [31:0] w [4];
    w = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000D};
    bus.wb_addr = 32'h0000_0040;
    bus.wb_line = {w[3], w[2], w[1], w[0]};
    bus.wb_req  = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ctl(), bus.mem_addr} !== {5'b11100, w[k], 32'(32'h40 + 4 * k)}) begin
        bad++; $display("FAIL capture_beat%0d got %h want %h", k, {ctl(), bus.mem_addr},
                        {5'b11100, w[k], 32'(32'h40 + 4 * k)});
      end
      if (k == 0) begin
        bus.wb_addr = 32'hFFFF_FFF0;
        bus.wb_line = '1;
      end
      tick();
    end
    total++;
    if (ctl() !== {5'b00110, 32'h0}) begin
      bad++; $display("FAIL capture_done got %h want %h", ctl(), {5'b00110, 32'h0});
    end
    bus.wb_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    w = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004};
    bus.wb_addr   = 32'h0000_0100;
    bus.wb_line   = {w[3], w[2], w[1], w[0]};
    bus.fill_addr = 32'h0000_0200;
    bus.wb_req    = 1'b1;
    bus.fill_req  = 1'b1;
    bus.mem_ack   = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ctl(), bus.mem_addr} !== {5'b11100, w[k], 32'(32'h100 + 4 * k)}) begin
        bad++; $display("FAIL both_wb_beat%0d got %h want %h", k, {ctl(), bus.mem_addr},
                        {5'b11100, w[k], 32'(32'h100 + 4 * k)});
      end
      tick();
    end
    total++;
    if (ctl() !== {5'b00110, 32'h0}) begin
      bad++; $display("FAIL both_wb_done got %h want %h", ctl(), {5'b00110, 32'h0});
    end
    bus.wb_req = 1'b0;
    tick();
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL both_gap_idle got %h want %h", ctl(), 37'h0);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ctl(), bus.mem_addr} !== {5'b10100, 32'h0, 32'(32'h200 + 4 * k)}) begin
        bad++; $display("FAIL both_fill_beat%0d got %h want %h", k, {ctl(), bus.mem_addr},
                        {5'b10100, 32'h0, 32'(32'h200 + 4 * k)});
      end
      bus.mem_rdata = 32'(32'hA0 + k);
      tick();
    end
    total++;
    if (ctl() !== {5'b00101, 32'h0}) begin
      bad++; $display("FAIL both_fill_done got %h want %h", ctl(), {5'b00101, 32'h0});
    end
    total++;
    if (bus.fill_line !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      bad++; $display("FAIL both_fill_line got %h want %h", bus.fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
    end
    bus.fill_req = 1'b0;
    bus.mem_ack  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    bus.fill_addr = 32'h0000_0400;
    bus.fill_req  = 1'b1;
    bus.mem_ack   = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.mem_rdata = 32'(32'h400 + k);
      tick();
    end
    total++;
    if ({ctl(), bus.mem_addr} !== {5'b10100, 32'h0, 32'h408}) begin
      bad++; $display("FAIL rst_pre_beat2 got %h want %h", {ctl(), bus.mem_addr}, {5'b10100, 32'h0, 32'h408});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL rst_async_ctl got %h want %h", ctl(), 37'h0);
    end
    total++;
    if (bus.fill_line !== 128'h0) begin
      bad++; $display("FAIL rst_async_fill_line got %h want %h", bus.fill_line, 128'h0);
    end
    bus.fill_addr = 32'h0000_0500;
    tick();
    total++;
    if (ctl() !== 37'h0) begin
      bad++; $display("FAIL rst_held_ctl got %h want %h", ctl(), 37'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ctl(), bus.mem_addr} !== {5'b10100, 32'h0, 32'(32'h500 + 4 * k)}) begin
        bad++; $display("FAIL rst_refill_beat%0d got %h want %h", k, {ctl(), bus.mem_addr},
                        {5'b10100, 32'h0, 32'(32'h500 + 4 * k)});
      end
      bus.mem_rdata = 32'(32'h5000 + k);
      tick();
    end
    total++;
    if (ctl() !== {5'b00101, 32'h0}) begin
      bad++; $display("FAIL rst_refill_done got %h want %h", ctl(), {5'b00101, 32'h0});
    end
    total++;
    if (bus.fill_line !== 128'h00005003_00005002_00005001_00005000) begin
      bad++; $display("FAIL rst_refill_line got %h want %h", bus.fill_line, 128'h00005003_00005002_00005001_00005000);
    end
    bus.fill_req = 1'b0;
    bus.mem_ack  = 1'b0;
    tick();
  endtask

  task automatic test_stray_ack();
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rdata = 32'(32'hDEAD_0000 + c);
      tick();
      total++;
      if (ctl() !== 37'h0) begin
        bad++; $display("FAIL stray_ack_cyc%0d got %h want %h", c, ctl(), 37'h0);
      end
      total++;
      if (bus.fill_line !== 128'h00005003_00005002_00005001_00005000) begin
        bad++; $display("FAIL stray_ack_line_cyc%0d got %h want %h", c, bus.fill_line,
                        128'h00005003_00005002_00005001_00005000);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wb_req    = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_line   = '0;
    bus.fill_req  = 1'b0;
    bus.fill_addr = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    test_reset();
    test_fill();
    test_wb_stall();
    test_input_change();
    test_back_to_back();
    test_reset_mid_fill();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
